// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam int LOADER_HDR_BYTES = 2;
  localparam int BYTE_W           = 8;

  // The loader consumes bytes exactly while a load is in progress.
  function automatic logic takes_bytes(loader_state_t s);
    return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, imem write port out. The loader sits on the slave side of the stream.
interface imem_loader_if #(
  parameter int WIDTH = 32,
  parameter int INDEX = 6
) ();

  logic             byte_valid_in;
  logic [7:0]       byte_data_in;
  logic             byte_ready_out;
  logic             imem_we_out;
  logic [INDEX-1:0] imem_addr_out;
  logic [WIDTH-1:0] imem_data_out;

  modport slave (
    input  byte_valid_in, byte_data_in,
    output byte_ready_out, imem_we_out, imem_addr_out, imem_data_out
  );

  modport master (
    output byte_valid_in, byte_data_in,
    input  byte_ready_out, imem_we_out, imem_addr_out, imem_data_out
  );

endinterface

// File: rtl/imem_loader_packer.sv
// Packs accepted bytes little-endian into a word; word_done_out pulses the cycle after the last lane fills.
module imem_loader_packer
  import imem_loader_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             clr_in,
  input  logic                             en_in,
  input  logic [BYTE_W-1:0]                byte_in,
  output logic [NUM_BYTES-1:0][BYTE_W-1:0] word_out,
  output logic                             word_done_out,
  output logic                             last_byte_out
);

  localparam int CW = $clog2(NUM_BYTES);

  logic [CW-1:0] cnt;

  assign last_byte_out = (cnt == CW'(NUM_BYTES - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      cnt           <= '0;
      word_done_out <= 1'b0;
    end else begin
      word_done_out <= en_in && last_byte_out;
      if (en_in) cnt <= last_byte_out ? '0 : cnt + CW'(1);
    end
  end

  // One register per byte lane; lane k captures the k-th byte of the word.
  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
    localparam logic [CW-1:0] LANE = CW'(g);
    always_ff @(posedge clk_in) begin
      if (rst_in)                    word_out[g] <= '0;
      else if (en_in && cnt == LANE) word_out[g] <= byte_in;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header (word count) then program bytes -> imem words 0..N-1, core held in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INDEX = 6
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           load_req_in,
  imem_loader_if.slave   bus,
  output logic           core_nrst_out,
  output logic           busy_out,
  output logic           done_out,
  output logic           error_out,
  output logic [INDEX:0] words_out
);

  localparam int          NUM_BYTES = WIDTH / BYTE_W;
  localparam logic [16:0] DEPTH     = 17'(2 ** INDEX);

  loader_state_t                    state;
  logic [7:0]                       hdr_lo;
  logic [15:0]                      hdr;
  logic [INDEX:0]                   n_words;
  logic [INDEX-1:0]                 addr;
  logic                             accept, idle_like, pk_clr, pk_en, pk_last, pk_done;
  logic [NUM_BYTES-1:0][BYTE_W-1:0] pk_word;

  assign bus.byte_ready_out = takes_bytes(state);
  assign busy_out           = takes_bytes(state);
  assign accept             = bus.byte_valid_in && bus.byte_ready_out;
  assign idle_like          = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  assign pk_clr             = idle_like && load_req_in;
  assign pk_en              = accept && (state == ST_DATA);
  assign hdr                = {bus.byte_data_in, hdr_lo};

  // Write strobe and data come straight from the packer's registers, so the
  // pulse lands exactly one cycle after the fourth byte is accepted.
  assign bus.imem_we_out   = pk_done;
  assign bus.imem_addr_out = addr;
  assign bus.imem_data_out = pk_word;

  imem_loader_packer #(.NUM_BYTES(NUM_BYTES)) u_packer (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .clr_in        (pk_clr),
    .en_in         (pk_en),
    .byte_in       (bus.byte_data_in),
    .word_out      (pk_word),
    .word_done_out (pk_done),
    .last_byte_out (pk_last)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= ST_IDLE;
      hdr_lo        <= '0;
      n_words       <= '0;
      addr          <= '0;
      words_out     <= '0;
      done_out      <= 1'b0;
      error_out     <= 1'b0;
      core_nrst_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          // Release one cycle after entering DONE, so the last write precedes any fetch.
          if (state == ST_DONE) core_nrst_out <= 1'b1;
          if (load_req_in) begin
            state         <= ST_HDR_LO;
            done_out      <= 1'b0;
            error_out     <= 1'b0;
            words_out     <= '0;
            core_nrst_out <= 1'b0;
          end
        end
        ST_HDR_LO: begin
          if (accept) begin
            hdr_lo <= bus.byte_data_in;
            state  <= ST_HDR_HI;
          end
        end
        ST_HDR_HI: begin
          if (accept) begin
            if (hdr == 16'd0 || {1'b0, hdr} > DEPTH) begin
              state     <= ST_ERROR;
              error_out <= 1'b1;
            end else begin
              n_words <= hdr[INDEX:0];
              state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept && pk_last) begin
            addr      <= words_out[INDEX-1:0];
            words_out <= words_out + (INDEX+1)'(1);
            if (words_out == n_words - (INDEX+1)'(1)) begin
              state    <= ST_DONE;
              done_out <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized checks of imem_loader against a byte-list reference model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int WIDTH = 32;
  localparam int INDEX = 6;
  localparam int DEPTH = 64;

  typedef logic [7:0] byte_q_t[$];

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load_req = 1'b0;
  logic           core_nrst, busy, done, err;
  logic [INDEX:0] words;

  imem_loader_if #(.WIDTH(WIDTH), .INDEX(INDEX)) bus ();

  imem_loader #(.WIDTH(WIDTH), .INDEX(INDEX)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .load_req_in   (load_req),
    .bus           (bus),
    .core_nrst_out (core_nrst),
    .busy_out      (busy),
    .done_out      (done),
    .error_out     (err),
    .words_out     (words)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed write log, sampled just after each rising edge.
  logic [INDEX-1:0] wr_addr[$];
  logic [WIDTH-1:0] wr_data[$];
  logic             wr_done[$];
  longint           wr_time[$];

  always @(posedge clk) begin
    #1;
    if (bus.imem_we_out === 1'b1) begin
      wr_addr.push_back(bus.imem_addr_out);
      wr_data.push_back(bus.imem_data_out);
      wr_done.push_back(done);
      wr_time.push_back($time);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_done.delete(); wr_time.delete();
  endtask

  // Called right after a negedge; returns right after the next one.
  task automatic pulse_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send(input string tag, input byte_q_t b, input int gap_pct);
    int  i      = 0;
    int  budget = 0;
    logic acc;
    while (i < b.size() && budget < 5000) begin
      if ($urandom_range(99) < gap_pct) begin
        bus.byte_valid_in = 1'b0;
        acc = 1'b0;
      end else begin
        bus.byte_valid_in = 1'b1;
        bus.byte_data_in  = b[i];
        acc = bus.byte_ready_out;
      end
      @(negedge clk);
      budget++;
      if (acc) i++;
    end
    bus.byte_valid_in = 1'b0;
    chk({tag, "_bytes_accepted"}, i, b.size());
  endtask

  // Reference: word i of the program is bytes 2+4i..5+4i little-endian, written to address i.
  task automatic check_load(input string tag, input byte_q_t b);
    int n;
    logic [WIDTH-1:0] w;
    n = {b[1], b[0]};
    chk({tag, "_nwrites"}, wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      w = {b[4*i+5], b[4*i+4], b[4*i+3], b[4*i+2]};
      chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
      chk($sformatf("%s_data%0d", tag, i), wr_data[i], w);
    end
    if (wr_done.size() > 0) chk({tag, "_done_with_last_we"}, wr_done[wr_done.size()-1], 1'b1);
  endtask

  function automatic byte_q_t rand_prog(input int n);
    byte_q_t b;
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    for (int i = 0; i < 4*n; i++) b.push_back(8'($urandom));
    return b;
  endfunction

  initial begin
    byte_q_t          b;
    logic [WIDTH-1:0] ref_data[$];

    bus.byte_valid_in = 1'b0;
    bus.byte_data_in  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: core held, nothing accepted, no writes.
    repeat (10) @(negedge clk);
    chk("rst_core_nrst", core_nrst, 1'b0);
    chk("rst_ready", bus.byte_ready_out, 1'b0);
    chk("rst_we", bus.imem_we_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", err, 1'b0);
    chk("rst_words", words, 0);
    chk("rst_no_writes", wr_addr.size(), 0);

    // Directed two-word program.
    clear_log();
    pulse_req();
    chk("d_ready_hdr", bus.byte_ready_out, 1'b1);
    chk("d_busy_hdr", busy, 1'b1);
    b = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    send("d", b, 0);
    chk("d_we_last", bus.imem_we_out, 1'b1);
    chk("d_addr_last", bus.imem_addr_out, 1);
    chk("d_data_last", bus.imem_data_out, 32'h0020_0093);
    chk("d_done_with_we", done, 1'b1);
    chk("d_core_still_held", core_nrst, 1'b0);
    chk("d_words", words, 2);
    check_load("d", b);
    @(negedge clk);
    chk("d_core_released", core_nrst, 1'b1);
    chk("d_we_single", bus.imem_we_out, 1'b0);
    chk("d_ready_done", bus.byte_ready_out, 1'b0);
    chk("d_busy_done", busy, 1'b0);

    // Reload from DONE: core re-held next cycle, new program overwrites address 0.
    clear_log();
    pulse_req();
    chk("r_core_held", core_nrst, 1'b0);
    chk("r_done_clr", done, 1'b0);
    chk("r_words_clr", words, 0);
    chk("r_busy", busy, 1'b1);
    b = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send("r", b, 0);
    check_load("r", b);
    chk("r_data_deadbeef", bus.imem_data_out, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("r_core_released", core_nrst, 1'b1);

    // Zero-length header -> ERROR.
    clear_log();
    pulse_req();
    b = '{8'h00, 8'h00};
    send("e0", b, 0);
    chk("e0_error", err, 1'b1);
    chk("e0_ready", bus.byte_ready_out, 1'b0);
    chk("e0_core_held", core_nrst, 1'b0);
    chk("e0_busy", busy, 1'b0);
    chk("e0_done", done, 1'b0);
    bus.byte_valid_in = 1'b1;
    bus.byte_data_in  = 8'h55;
    repeat (6) @(negedge clk);
    bus.byte_valid_in = 1'b0;
    chk("e0_error_held", err, 1'b1);
    chk("e0_no_writes", wr_addr.size(), 0);

    // One past DEPTH -> ERROR.
    pulse_req();
    chk("e41_error_clr", err, 1'b0);
    b = '{8'h41, 8'h00};
    send("e41", b, 0);
    chk("e41_error", err, 1'b1);
    chk("e41_core_held", core_nrst, 1'b0);

    // Full-depth program, gapless: 64 writes, one pulse every 4 cycles.
    clear_log();
    pulse_req();
    b = rand_prog(DEPTH);
    send("full", b, 0);
    check_load("full", b);
    chk("full_done", done, 1'b1);
    chk("full_words", words, DEPTH);
    chk("full_last_addr", bus.imem_addr_out, DEPTH - 1);
    for (int i = 1; i < wr_time.size(); i++)
      chk($sformatf("full_pulse_gap%0d", i), 32'(wr_time[i] - wr_time[i-1]), 40);

    // Three-word program, gapless then with 50% valid gaps: identical writes.
    b = rand_prog(3);
    clear_log();
    pulse_req();
    send("g0", b, 0);
    check_load("g0", b);
    ref_data = wr_data;
    clear_log();
    pulse_req();
    send("g50", b, 50);
    check_load("g50", b);
    for (int i = 0; i < ref_data.size() && i < wr_data.size(); i++)
      chk($sformatf("g50_vs_g0_%0d", i), wr_data[i], ref_data[i]);
    repeat (2) @(negedge clk);
    chk("g50_core_released", core_nrst, 1'b1);

    // Reset after two data bytes: partial word dropped, core held, reload works.
    clear_log();
    pulse_req();
    b = '{8'h03, 8'h00, 8'hAA, 8'hBB};
    send("mr", b, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_ready", bus.byte_ready_out, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_core_held", core_nrst, 1'b0);
    chk("mr_words", words, 0);
    repeat (5) @(negedge clk);
    chk("mr_no_writes", wr_addr.size(), 0);
    chk("mr_core_still_held", core_nrst, 1'b0);
    b = rand_prog(1);
    pulse_req();
    send("mr_reload", b, 0);
    check_load("mr_reload", b);

    // load_req mid-DATA is ignored.
    @(negedge clk);
    clear_log();
    b = rand_prog(2);
    pulse_req();
    send("lq_a", b[0:3], 0);
    pulse_req();
    chk("lq_busy", busy, 1'b1);
    chk("lq_ready", bus.byte_ready_out, 1'b1);
    send("lq_b", b[4:$], 0);
    check_load("lq", b);
    chk("lq_words", words, 2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
